// File: rtl/blockmem_arb_pkg.sv
// Shared constants and types for blockmem_arbiter and its sub-blocks.
package blockmem_arb_pkg;

    localparam int unsigned CLIENTS   = 2;
    localparam int unsigned DATA_BITS = 32;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef logic [DATA_BITS-1:0] word_t;

endpackage

// File: rtl/blockmem_arbiter_if.sv
// Client-side request/response bundle of blockmem_arbiter.
// Per-client fields are packed as slices, client i in slice i.
interface blockmem_arbiter_if
    import blockmem_arb_pkg::*;
#(
    parameter int unsigned WORD_COUNT = 32
);
    localparam int unsigned ADDR_BITS = $clog2(WORD_COUNT);

    logic [CLIENTS-1:0]           req_valid;
    logic [CLIENTS-1:0]           req_write;
    logic [CLIENTS*ADDR_BITS-1:0] req_addr;
    logic [CLIENTS*DATA_BITS-1:0] req_wdata;
    logic [CLIENTS-1:0]           req_ready;
    logic [CLIENTS-1:0]           rsp_valid;
    logic [DATA_BITS-1:0]         rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; a lone requester always wins, on contention
// the client that was not granted last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // Index of the most recently granted client; resets to 1 so client 0 wins first.
    logic last;

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (|grant) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/blockmem_arbiter.sv
// Shares one blockmem (1R + 1W, 1-cycle registered read) between two clients,
// with independent round-robin arbitration per port. Optional write-first
// forwarding of same-address read/write collisions: BLOCKMEM_ARB_FWD_EN.
module blockmem_arbiter
    import blockmem_arb_pkg::*;
#(
    parameter  int unsigned WORD_COUNT = 32,
    localparam int unsigned ADDR_BITS  = $clog2(WORD_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    blockmem_arbiter_if.slave     clients,
    output logic                  mem_read_en,
    output logic [ADDR_BITS-1:0]  mem_raddr,
    input  logic [DATA_BITS-1:0]  mem_rdata,
    output logic                  mem_write_en,
    output logic [ADDR_BITS-1:0]  mem_waddr,
    output logic [DATA_BITS-1:0]  mem_wdata
);

    logic [CLIENTS-1:0] rd_req;
    logic [CLIENTS-1:0] wr_req;
    logic [CLIENTS-1:0] rd_grant;
    logic [CLIENTS-1:0] wr_grant;
    logic [CLIENTS-1:0] rsp_tag;

    always_comb begin
        rd_req = '0;
        wr_req = '0;
        for (int unsigned i = 0; i < CLIENTS; i++) begin
            rd_req[i] = clients.req_valid[i] && (clients.req_write[i] == OP_READ);
            wr_req[i] = clients.req_valid[i] && (clients.req_write[i] == OP_WRITE);
        end
    end

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (rd_req),
        .grant (rd_grant)
    );

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (wr_req),
        .grant (wr_grant)
    );

    // A client has only one op pending, so at most one of its grants is set.
    assign clients.req_ready = rd_grant | wr_grant;

    always_comb begin
        mem_read_en  = |rd_grant;
        mem_write_en = |wr_grant;
        mem_raddr    = '0;
        mem_waddr    = '0;
        mem_wdata    = '0;
        for (int unsigned i = 0; i < CLIENTS; i++) begin
            if (rd_grant[i]) begin
                mem_raddr = clients.req_addr[i*ADDR_BITS +: ADDR_BITS];
            end
            if (wr_grant[i]) begin
                mem_waddr = clients.req_addr[i*ADDR_BITS +: ADDR_BITS];
                mem_wdata = clients.req_wdata[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_tag <= '0;
        end else begin
            rsp_tag <= rd_grant;
        end
    end

    assign clients.rsp_valid = rsp_tag;

`ifdef BLOCKMEM_ARB_FWD_EN
    logic  fwd_hit;
    word_t fwd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            fwd_hit  <= mem_read_en && mem_write_en && (mem_raddr == mem_waddr);
            fwd_data <= mem_wdata;
        end
    end

    assign clients.rsp_rdata = (rsp_tag == '0) ? '0 : (fwd_hit ? fwd_data : mem_rdata);
`else
    assign clients.rsp_rdata = (rsp_tag == '0) ? '0 : mem_rdata;
`endif

endmodule
